// File: rtl/apb_slave_regbank.sv
// apb_slave_regbank
// APB4 completer that holds a bank of 32-bit registers. Word 0 is a read-only
// ID register. Every other word is byte-writable storage. Each transfer gets
// WAIT_CYCLES wait states before PREADY. Illegal accesses complete with
// PSLVERROR.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   PSEL       completer select
//   PENABLE    access-phase indicator
//   PWRITE     1 = write, 0 = read
//   PADDR      byte address; only [SLV_ADDR_WIDTH-1:0] is decoded here
//   PWDATA     write data
//   PSTRB      write byte strobes
//   PREADY     registered transfer-complete
//   PRDATA     registered read data, zero except while PREADY is high
//   PSLVERROR  registered error response, only ever high with PREADY
//   xfer_done  one-cycle pulse on the cycle after each completed transfer
module apb_slave_regbank #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 10,
    parameter int                    SLV_ADDR_WIDTH = 8,
    parameter int                    WAIT_CYCLES    = 1,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE       = 32'hA9B4_0001
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERROR,
    output logic                    xfer_done
);

    localparam int IDX_W  = SLV_ADDR_WIDTH - 2;
    localparam int DEPTH  = 2 ** IDX_W;
    localparam int STRB_W = DATA_WIDTH / 8;
    // The counter is loaded with WAIT_CYCLES-1 so that it reaches zero on the
    // last wait state. This value is never used when WAIT_CYCLES is 0.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [SLV_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                      write_q, write_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]         strb_q, strb_d;
    logic                      pready_q, pready_d;
    logic [DATA_WIDTH-1:0]     prdata_q, prdata_d;
    logic                      pslverror_q, pslverror_d;
    logic                      xfer_done_q, xfer_done_d;
    logic [DATA_WIDTH-1:0]     mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]     mem_d [DEPTH];

    // The response is computed on the edge that enters RESP. With zero wait
    // states, that edge is the setup edge itself. In that case the request
    // comes straight from the bus instead of from the latched copy.
    logic [SLV_ADDR_WIDTH-1:0] req_addr;
    logic                      req_write;
    logic [IDX_W-1:0]          req_idx;
    logic                      req_err;
    logic [DATA_WIDTH-1:0]     req_rdata;
    logic [DATA_WIDTH-1:0]     merged;

    // Upper address bits are decoded upstream and are intentionally ignored.
    logic unused_paddr;
    assign unused_paddr = ^PADDR[ADDR_WIDTH-1:SLV_ADDR_WIDTH];

    assign req_addr  = (state_q == S_IDLE) ? PADDR[SLV_ADDR_WIDTH-1:0] : addr_q;
    assign req_write = (state_q == S_IDLE) ? PWRITE : write_q;
    assign req_idx   = req_addr[SLV_ADDR_WIDTH-1:2];
    assign req_err   = (|req_addr[1:0]) || (req_write && (req_idx == '0));
    assign req_rdata = (req_write || req_err) ? '0 :
                       (req_idx == '0)        ? ID_VALUE : mem_q[req_idx];

    // Merge the strobed lanes of the latched write data into the stored word.
    always_comb begin
        merged = mem_q[addr_q[SLV_ADDR_WIDTH-1:2]];
        for (int i = 0; i < STRB_W; i++) begin
            if (strb_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    // Next-state logic for the transfer FSM, the response registers and the
    // storage. The response outputs default to zero, so they can only be
    // nonzero on the single cycle spent in RESP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        pready_d    = 1'b0;
        prdata_d    = '0;
        pslverror_d = 1'b0;
        xfer_done_d = 1'b0;
        mem_d       = mem_q;
        case (state_q)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    addr_d  = PADDR[SLV_ADDR_WIDTH-1:0];
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    strb_d  = PSTRB;
                    if (WAIT_CYCLES == 0) begin
                        state_d     = S_RESP;
                        pready_d    = 1'b1;
                        prdata_d    = req_rdata;
                        pslverror_d = req_err;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d     = S_RESP;
                    pready_d    = 1'b1;
                    prdata_d    = req_rdata;
                    pslverror_d = req_err;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                // If PSEL is low here, the master has abandoned the transfer.
                // Nothing is committed and no pulse is produced.
                if (PSEL) begin
                    xfer_done_d = 1'b1;
                    if (write_q && !pslverror_q) begin
                        mem_d[addr_q[SLV_ADDR_WIDTH-1:2]] = merged;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // All state, including storage, is cleared asynchronously. A write that
    // is in flight when reset asserts is therefore lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            strb_q      <= '0;
            pready_q    <= 1'b0;
            prdata_q    <= '0;
            pslverror_q <= 1'b0;
            xfer_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            pready_q    <= pready_d;
            prdata_q    <= prdata_d;
            pslverror_q <= pslverror_d;
            xfer_done_q <= xfer_done_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign PREADY    = pready_q;
    assign PRDATA    = prdata_q;
    assign PSLVERROR = pslverror_q;
    assign xfer_done = xfer_done_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// tb_apb_slave_regbank
// Drives three copies of the register bank, with 0, 1 and 3 wait states,
// through directed and random APB transfers. Results are checked against a
// word-array model of the bank that applies the access rules directly.
module tb_apb_slave_regbank;

    localparam logic [31:0] ID = 32'hA9B4_0001;

    logic        clk;
    logic        reset;
    logic        psel      [3];
    logic        penable   [3];
    logic        pwrite    [3];
    logic [9:0]  paddr     [3];
    logic [31:0] pwdata    [3];
    logic [3:0]  pstrb     [3];
    logic        pready    [3];
    logic [31:0] prdata    [3];
    logic        pslverror [3];
    logic        xfer_done [3];

    int          wait_of [3] = '{0, 1, 3};
    logic [31:0] model_mem [3][64];
    bit          expect_done [3];
    int          checks = 0;
    int          errors = 0;

    apb_slave_regbank #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
        .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERROR(pslverror[0]),
        .xfer_done(xfer_done[0]));

    apb_slave_regbank #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .reset(reset), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
        .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERROR(pslverror[1]),
        .xfer_done(xfer_done[1]));

    apb_slave_regbank #(.WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset(reset), .PSEL(psel[2]), .PENABLE(penable[2]),
        .PWRITE(pwrite[2]), .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PSTRB(pstrb[2]),
        .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERROR(pslverror[2]),
        .xfer_done(xfer_done[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic clearModel();
        for (int k = 0; k < 3; k++) begin
            expect_done[k] = 1'b0;
            for (int w = 0; w < 64; w++) model_mem[k][w] = 32'h0;
        end
    endtask

    task automatic busIdle(input int k);
        psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
        paddr[k] = '0;  pwdata[k] = '0;    pstrb[k] = '0;
    endtask

    // Called in the cycle after a possible completion. It checks that each
    // pending xfer_done pulse is present and that no others are.
    task automatic checkDoneAll();
        for (int j = 0; j < 3; j++) begin
            checkOutput($sformatf("xfer_done%0d", j), {31'b0, xfer_done[j]},
                        {31'b0, expect_done[j]});
            expect_done[j] = 1'b0;
        end
    endtask

    task automatic applyIdle(input int k);
        busIdle(k);
        @(negedge clk);
        checkDoneAll();
        checkOutput("idle_pready", {31'b0, pready[k]}, 32'h0);
        checkOutput("idle_prdata", prdata[k], 32'h0);
        @(posedge clk); #1;
    endtask

    // Runs one full transfer on instance k. The expected result comes from the
    // model. Entered and left at 1 time unit after a rising edge, so the next
    // call can start a back-to-back setup phase.
    task automatic applyStimulus(input int k, input bit wr, input logic [9:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb,
                                 output logic [31:0] rdata_obs);
        int          idx;
        bit          exp_err;
        logic [31:0] exp_data;
        logic [31:0] cur;
        int          cyc;
        bit          got;
        idx      = int'(addr[7:2]);
        exp_err  = (addr[1:0] != 2'b00) || (wr && idx == 0);
        exp_data = (exp_err || wr) ? 32'h0 : (idx == 0) ? ID : model_mem[k][idx];
        psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr;
        paddr[k] = addr; pwdata[k] = wdata; pstrb[k] = strb;
        @(negedge clk);
        checkDoneAll();
        checkOutput("setup_pready", {31'b0, pready[k]}, 32'h0);
        @(posedge clk); #1;
        penable[k] = 1'b1;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (pready[k] === 1'b1) begin
                got = 1'b1;
            end else begin
                checkOutput("wait_prdata", prdata[k], 32'h0);
                checkOutput("wait_slverr", {31'b0, pslverror[k]}, 32'h0);
                @(posedge clk); #1;
            end
        end
        checkOutput($sformatf("latency_w%0d", wait_of[k]), cyc, wait_of[k] + 1);
        rdata_obs = prdata[k];
        if (got) begin
            checkOutput("pslverror", {31'b0, pslverror[k]}, {31'b0, exp_err});
            if (!wr || exp_err) checkOutput("prdata", prdata[k], exp_data);
            @(posedge clk); #1;
        end
        busIdle(k);
        if (got && wr && !exp_err) begin
            cur = model_mem[k][idx];
            for (int b = 0; b < 4; b++)
                if (strb[b]) cur[8*b +: 8] = wdata[8*b +: 8];
            model_mem[k][idx] = cur;
        end
        expect_done[k] = got;
    endtask

    initial begin
        logic [31:0] rd;
        int          k;
        bit          wr;
        logic [9:0]  addr;
        reset = 1'b1;
        for (int j = 0; j < 3; j++) busIdle(j);
        clearModel();
        repeat (3) @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            checkOutput("rst_pready", {31'b0, pready[j]}, 32'h0);
            checkOutput("rst_prdata", prdata[j], 32'h0);
            checkOutput("rst_slverr", {31'b0, pslverror[j]}, 32'h0);
            checkOutput("rst_done", {31'b0, xfer_done[j]}, 32'h0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] read after reset, one wait state");
        applyStimulus(1, 1'b0, 10'h014, 32'h0, 4'h0, rd);
        checkOutput("read_word5", rd, 32'h0);
        applyIdle(1);

        $display("[TB] full and partial byte-lane writes");
        applyStimulus(1, 1'b1, 10'h008, 32'hDEADBEEF, 4'b1111, rd);
        applyStimulus(1, 1'b1, 10'h008, 32'h00001122, 4'b0011, rd);
        applyStimulus(1, 1'b0, 10'h008, 32'h0, 4'h0, rd);
        checkOutput("strobe_merge", rd, 32'hDEAD1122);

        $display("[TB] ID register and illegal accesses");
        applyStimulus(1, 1'b0, 10'h000, 32'h0, 4'h0, rd);
        checkOutput("id_read", rd, ID);
        applyStimulus(1, 1'b1, 10'h000, 32'h0, 4'hF, rd);
        applyStimulus(1, 1'b0, 10'h000, 32'h0, 4'h0, rd);
        checkOutput("id_reread", rd, ID);
        applyStimulus(1, 1'b1, 10'h00A, 32'hFFFFFFFF, 4'hF, rd);
        applyStimulus(1, 1'b0, 10'h008, 32'h0, 4'h0, rd);
        checkOutput("after_unaligned", rd, 32'hDEAD1122);
        applyStimulus(1, 1'b1, 10'h00C, 32'h12345678, 4'h0, rd);
        applyStimulus(1, 1'b0, 10'h00C, 32'h0, 4'h0, rd);
        checkOutput("strb_zero_noop", rd, 32'h0);
        applyIdle(1);

        $display("[TB] back-to-back transfers with zero and three wait states");
        for (int j = 0; j < 3; j += 2) begin
            applyStimulus(j, 1'b1, 10'h010, 32'hA5A5_0010, 4'hF, rd);
            applyStimulus(j, 1'b1, 10'h014, 32'h5A5A_0014, 4'hF, rd);
            applyStimulus(j, 1'b0, 10'h010, 32'h0, 4'h0, rd);
            checkOutput("b2b_rd10", rd, 32'hA5A5_0010);
            applyStimulus(j, 1'b0, 10'h014, 32'h0, 4'h0, rd);
            checkOutput("b2b_rd14", rd, 32'h5A5A_0014);
            applyIdle(j);
        end

        $display("[TB] master drops PSEL during wait states");
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 10'h020; pwdata[2] = 32'h55; pstrb[2] = 4'hF;
        @(posedge clk); #1;
        penable[2] = 1'b1;
        @(negedge clk);
        checkOutput("abort_pready_a", {31'b0, pready[2]}, 32'h0);
        @(posedge clk); #1;
        busIdle(2);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checkOutput("abort_pready", {31'b0, pready[2]}, 32'h0);
            checkOutput("abort_done", {31'b0, xfer_done[2]}, 32'h0);
            @(posedge clk); #1;
        end
        applyStimulus(2, 1'b0, 10'h020, 32'h0, 4'h0, rd);
        checkOutput("abort_nowrite", rd, 32'h0);
        applyIdle(2);

        $display("[TB] random transfers");
        for (int n = 0; n < 90; n++) begin
            k  = int'($urandom_range(0, 2));
            wr = 1'($urandom_range(0, 1));
            addr[9:8] = 2'($urandom);
            addr[7:2] = 6'($urandom);
            addr[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 3) == 0) addr[7:2] = 6'd0;
            applyStimulus(k, wr, addr, $urandom, 4'($urandom), rd);
            if ($urandom_range(0, 2) == 0) applyIdle(k);
        end
        applyIdle(0);

        $display("[TB] reset in the middle of a write");
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 10'h030; pwdata[1] = 32'hCAFEF00D; pstrb[1] = 4'hF;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) begin
            checkOutput("midrst_pready", {31'b0, pready[j]}, 32'h0);
            checkOutput("midrst_prdata", prdata[j], 32'h0);
            checkOutput("midrst_slverr", {31'b0, pslverror[j]}, 32'h0);
            checkOutput("midrst_done", {31'b0, xfer_done[j]}, 32'h0);
        end
        busIdle(1);
        clearModel();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        for (int j = 0; j < 3; j++) begin
            for (int w = 1; w < 64; w += 7) begin
                applyStimulus(j, 1'b0, 10'(w * 4), 32'h0, 4'h0, rd);
                checkOutput("post_rst_zero", rd, 32'h0);
            end
            applyStimulus(j, 1'b0, 10'h030, 32'h0, 4'h0, rd);
            checkOutput("post_rst_lost", rd, 32'h0);
            applyIdle(j);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_slave_regbank.md
Name: apb_slave_regbank

Overview:
- APB4 completer (responder) holding a bank of 32-bit registers; the target that sits behind one PSELx line of apb_master.
- Services one transfer at a time with a parameterised number of wait states, byte-lane writes via PSTRB, and PSLVERROR on illegal accesses.
- Word 0 is a read-only ID register; all other words are read/write storage.

Parameters:
- DATA_WIDTH, 32, PWDATA/PRDATA width; fixed at 32 for this block.
- ADDR_WIDTH, 10, PADDR width.
- SLV_ADDR_WIDTH, 8, byte-address bits decoded locally; bank depth = 2^(SLV_ADDR_WIDTH-2) words (64).
- WAIT_CYCLES, 1, wait states inserted before PREADY (0..15).
- ID_VALUE, 32'hA9B4_0001, constant read from word 0.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- PSEL  input  1  select for this completer (one bit of PSELx).
- PENABLE  input  1  access-phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  ADDR_WIDTH  byte address; only [SLV_ADDR_WIDTH-1:0] used.
- PWDATA  input  DATA_WIDTH  write data.
- PSTRB  input  DATA_WIDTH/8  write byte strobes.
- PREADY  output  1  transfer-complete, registered.
- PRDATA  output  DATA_WIDTH  read data, registered.
- PSLVERROR  output  1  error response, registered.
- xfer_done  output  1  one-cycle pulse on the cycle after each completed transfer (monitor/debug).

Behaviour:
- Reset (async, active-high): PREADY=0, PRDATA=0, PSLVERROR=0, xfer_done=0, FSM=IDLE, wait counter=0, all storage words=0.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on an edge with PSEL=1 and PENABLE=0 (setup), latch PADDR, PWRITE, PWDATA, PSTRB. Then:
    - if WAIT_CYCLES=0, go to RESP and set PREADY<=1;
    - else load counter=WAIT_CYCLES-1 and go to WAIT.
  - WAIT: PREADY=0. If PSEL=0, go to IDLE (abort; no write, no pulse). If counter=0, go to RESP with PREADY<=1. Otherwise decrement the counter.
  - RESP: PREADY=1 for exactly one cycle, together with PRDATA/PSLVERROR. At this edge PSEL&PENABLE=1 is expected:
    - commit the write (if any and not error);
    - go to IDLE; PREADY<=0, PRDATA<=0, PSLVERROR<=0, xfer_done<=1.
    - If PSEL=0 at this edge, abort: no commit, no pulse.
- Latency: PREADY rises on access cycle WAIT_CYCLES+1. A transfer occupies 2+WAIT_CYCLES clocks.
- Back-to-back: a new setup in the cycle immediately after completion is accepted from IDLE with no bubble beyond APB's own setup cycle.
- Address/error rules (word index = PADDR[SLV_ADDR_WIDTH-1:2]):
  - PADDR[1:0]!=0 → PSLVERROR=1; write suppressed; PRDATA=0.
  - Write to word 0 → PSLVERROR=1; ID unchanged.
  - Read of word 0 → ID_VALUE, no error.
  - PADDR bits above SLV_ADDR_WIDTH are ignored (decode is done upstream).
- Write: byte lane i is updated iff PSTRB[i]=1. PSTRB=0 is a legal no-op with no error.
- Read: PSTRB is ignored. PRDATA holds the word value only while PREADY=1, else 0.
- PSLVERROR is only ever 1 while PREADY=1.
- Reset asserted mid-transfer clears everything immediately. The in-flight write is lost; the master sees PREADY=0.

Test Plan:
- Reset then read word 5 (PADDR=0x14), WAIT_CYCLES=1 → PREADY high on 2nd access cycle, PRDATA=0, PSLVERROR=0, xfer_done pulses next cycle.
- Write 0xDEADBEEF to 0x08 with PSTRB=4'b1111, then write 0x00001122 with PSTRB=4'b0011, then read 0x08 → PRDATA=0xDEAD1122.
- Read 0x00 → PRDATA=0xA9B40001. Write 0x0 to 0x00 → PSLVERROR=1 with PREADY; a re-read still returns 0xA9B40001.
- Write to unaligned 0x0A → PSLVERROR=1. Read 0x08 → previous value unchanged.
- WAIT_CYCLES=0 vs 3, back-to-back writes to 0x10 and 0x14 → PREADY on 1st vs 4th access cycle. No idle cycle is needed between transfers, and both values read back correctly.
- Drop PSEL during WAIT (WAIT_CYCLES=3) on a write of 0x55 to 0x20 → no PREADY, no xfer_done, 0x20 still reads 0. Separately, assert reset mid-write → all outputs 0 immediately and all words read back 0.
